multicycle_alu: RTL and testbench

- Parametrised, registered successor to the single-cycle ALU for the multi-cycle MIPS datapath.
- Adds logic, shift, signed/unsigned compare and overflow detection to the existing ops.
- Adds an iterative multiply/divide unit that writes HI/LO registers.
- Operations are launched with a start/busy/done handshake so the control FSM can stall on long ops.

---
 rtl/multicycle_alu.sv | 268 ++++++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu
//
// Registered ALU for the multi-cycle MIPS datapath. Single-cycle operations
// (logic, add/sub, compares, shifts) land in result/zero/overflow. Multiply
// and divide run iteratively, one bit per cycle, and land in hi/lo. Every
// operation is launched with start and finishes with a one-cycle done pulse,
// so the control FSM can simply stall on busy.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        launch an operation (accepted only when idle)
//   a, b         operands; b[SHW-1:0] is the shift amount for shifts
//   alu_control  operation select
//   result       registered result of single-cycle operations
//   zero         result == 0, registered together with result
//   overflow     signed overflow of ADD/SUB
//   hi, lo       multiply upper/lower half, divide remainder/quotient
//   busy         high while a multiply or divide is iterating
//   done         one-cycle pulse when an operation completes
//   div_zero     raised with done when a divide had b == 0
// ---------------------------------------------------------------------------
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpNor  = 4'b0100;
  localparam logic [3:0] OpSltu = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // What the DONE state has to write back once the operation finishes.
  typedef enum logic [1:0] {KindAlu, KindMul, KindDiv, KindDivZero} kind_t;

  state_t              state_q;
  kind_t               kind_q;
  logic [WIDTH-1:0]    result_q;
  logic                zero_q;
  logic                overflow_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;
  logic                busy_q;
  logic                done_q;
  logic                divZero_q;

  logic [2*WIDTH-1:0]  prod_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [WIDTH-1:0]    rem_q;
  logic [WIDTH-1:0]    quot_q;
  logic [WIDTH-1:0]    dsor_q;
  logic [WIDTH-1:0]    dividend_q;
  logic [SHW-1:0]      cnt_q;
  logic                negLo_q;
  logic                negHi_q;

  logic [WIDTH-1:0]    aluResult_d;
  logic                aluOverflow_d;
  logic [WIDTH-1:0]    addSum;
  logic [WIDTH-1:0]    subDiff;
  logic [SHW-1:0]      shamt;
  logic                signedOp;
  logic [WIDTH-1:0]    aMag;
  logic [WIDTH-1:0]    bMag;
  logic [WIDTH:0]      mulSum_d;
  logic [WIDTH:0]      divShift_d;
  logic [WIDTH:0]      divDiff_d;
  logic [2*WIDTH-1:0]  prodFinal;
  logic [WIDTH-1:0]    quotFinal;
  logic [WIDTH-1:0]    remFinal;

  assign addSum   = a + b;
  assign subDiff  = a - b;
  assign shamt    = b[SHW-1:0];

  // MULT and DIV are the even encodings of the multi-cycle group; both work
  // on operand magnitudes and fix up the signs once the iteration is over.
  assign signedOp = ~alu_control[0];
  assign aMag     = (signedOp && a[WIDTH-1]) ? -a : a;
  assign bMag     = (signedOp && b[WIDTH-1]) ? -b : b;

  // One shift-add step: the low half of prod_q holds the remaining
  // multiplier bits, the high half accumulates; the carry is kept in the
  // extra bit so nothing is lost when the pair shifts right.
  assign mulSum_d   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  // One restoring-divide step: bring down the next dividend bit and try to
  // subtract the divisor; a borrow in the top bit means "restore".
  assign divShift_d = {rem_q, quot_q[WIDTH-1]};
  assign divDiff_d  = divShift_d - {1'b0, dsor_q};

  assign prodFinal  = negLo_q ? -prod_q : prod_q;
  assign quotFinal  = negLo_q ? -quot_q : quot_q;
  assign remFinal   = negHi_q ? -rem_q  : rem_q;

  // Single-cycle datapath. It looks at the live inputs because it is only
  // sampled on the cycle a start is accepted; the multi-cycle encodings and
  // the reserved code fall through to zero with no overflow.
  always_comb begin
    aluResult_d   = '0;
    aluOverflow_d = 1'b0;
    case (alu_control)
      OpAnd:  aluResult_d = a & b;
      OpOr:   aluResult_d = a | b;
      OpXor:  aluResult_d = a ^ b;
      OpNor:  aluResult_d = ~(a | b);
      OpAdd: begin
        aluResult_d   = addSum;
        aluOverflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        aluResult_d   = subDiff;
        aluOverflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (subDiff[WIDTH-1] != a[WIDTH-1]);
      end
      OpSlt:  aluResult_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu: aluResult_d = {{(WIDTH-1){1'b0}}, (a < b)};
      OpSll:  aluResult_d = a << shamt;
      OpSrl:  aluResult_d = a >> shamt;
      OpSra:  aluResult_d = $unsigned($signed(a) >>> shamt);
      default: aluResult_d = '0;
    endcase
  end

  // Control FSM plus all datapath registers. Operands are captured on the
  // accepted start, so later input changes cannot disturb a running op.
  // A start is refused while done is still high, which keeps the cycle of
  // the done pulse free for the controller to react before launching again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      kind_q     <= KindAlu;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      divZero_q  <= 1'b0;
      prod_q     <= '0;
      mcand_q    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dsor_q     <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
      negLo_q    <= 1'b0;
      negHi_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !done_q) begin
            divZero_q <= 1'b0;
            cnt_q     <= '0;
            if (alu_control[3:2] != 2'b11) begin
              result_q   <= aluResult_d;
              zero_q     <= (aluResult_d == '0);
              overflow_q <= aluOverflow_d;
              kind_q     <= KindAlu;
              state_q    <= DONE;
            end else if (!alu_control[1]) begin
              prod_q  <= {{WIDTH{1'b0}}, bMag};
              mcand_q <= aMag;
              negLo_q <= signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
              negHi_q <= 1'b0;
              kind_q  <= KindMul;
              busy_q  <= 1'b1;
              state_q <= MUL;
            end else if (b == '0) begin
              dividend_q <= a;
              kind_q     <= KindDivZero;
              state_q    <= DONE;
            end else begin
              quot_q  <= aMag;
              rem_q   <= '0;
              dsor_q  <= bMag;
              negLo_q <= signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
              negHi_q <= signedOp && a[WIDTH-1];
              kind_q  <= KindDiv;
              busy_q  <= 1'b1;
              state_q <= DIV;
            end
          end
        end
        MUL: begin
          prod_q <= {mulSum_d, prod_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + SHW'(1);
          if (&cnt_q) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DIV: begin
          if (!divDiff_d[WIDTH]) begin
            rem_q  <= divDiff_d[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q  <= divShift_d[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + SHW'(1);
          if (&cnt_q) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
          case (kind_q)
            KindMul: begin
              hi_q <= prodFinal[2*WIDTH-1:WIDTH];
              lo_q <= prodFinal[WIDTH-1:0];
            end
            KindDiv: begin
              hi_q <= remFinal;
              lo_q <= quotFinal;
            end
            KindDivZero: begin
              hi_q      <= dividend_q;
              lo_q      <= '1;
              divZero_q <= 1'b1;
            end
            default: ;
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = divZero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_alu
//
// Scoreboard bench for multicycle_alu. Each issued operation pushes the
// expected outcome (computed with plain 64-bit arithmetic) into a queue; an
// independent monitor pops one entry every time done pulses and compares
// all architectural outputs, the start-to-done latency and the busy length.
// ---------------------------------------------------------------------------
module tb_multicycle_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    alu_control;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic          div_zero;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          latency;
    int          busyCycles;
    int          startCycle;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  int          busyCount = 0;

  logic [31:0] mResult = '0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic        mZero = 1'b0;
  logic        mOvf = 1'b0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Cycle index used to measure start-to-done latency.
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Reference model: signed values are widened to 64 bits so overflow,
  // full products and truncating division come straight from the language.
  task automatic predict(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, output exp_t e);
    longint      sa;
    longint      sb;
    longint      s;
    longint      q;
    longint      rm;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    int          sh;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    sh  = int'(bv[4:0]);
    r   = '0;
    ovf = 1'b0;
    p   = '0;
    e.op = op;
    e.dz = 1'b0;
    e.latency = 2;
    e.busyCycles = 0;
    e.startCycle = 0;
    if (op[3:2] != 2'b11) begin
      case (op)
        4'h0: r = av & bv;
        4'h1: r = av | bv;
        4'h2: begin s = sa + sb; r = s[31:0]; ovf = (s != longint'($signed(r))); end
        4'h6: begin s = sa - sb; r = s[31:0]; ovf = (s != longint'($signed(r))); end
        4'h3: r = av ^ bv;
        4'h4: r = ~(av | bv);
        4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
        4'h5: r = (av < bv) ? 32'd1 : 32'd0;
        4'h8: r = av << sh;
        4'h9: r = av >> sh;
        4'hA: begin s = sa >>> sh; r = s[31:0]; end
        default: r = '0;
      endcase
      mResult = r;
      mZero   = (r == 32'd0);
      mOvf    = ovf;
    end else begin
      case (op)
        4'hC: p = sa * sb;
        4'hD: p = {32'd0, av} * {32'd0, bv};
        4'hE: begin
          if (bv == 32'd0) p = {av, 32'hFFFF_FFFF};
          else begin q = sa / sb; rm = sa % sb; p = {rm[31:0], q[31:0]}; end
        end
        default: begin
          if (bv == 32'd0) p = {av, 32'hFFFF_FFFF};
          else p = {av % bv, av / bv};
        end
      endcase
      if (op[1] && bv == 32'd0) e.dz = 1'b1;
      else begin e.latency = 34; e.busyCycles = 32; end
      mHi = p[63:32];
      mLo = p[31:0];
    end
    e.result = mResult;
    e.zero   = mZero;
    e.ovf    = mOvf;
    e.hi     = mHi;
    e.lo     = mLo;
  endtask

  task automatic resetModel();
    mResult = '0; mHi = '0; mLo = '0; mZero = 1'b0; mOvf = 1'b0;
  endtask

  // Monitor: one scoreboard entry per done pulse. A done with nothing
  // outstanding (extra pulse, or a start that should have been ignored)
  // counts as an error.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy) busyCount++;
    if (done) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cycleCount);
      end else begin
        e = expQ.pop_front();
        checkOutput("result",   64'(result),   64'(e.result));
        checkOutput("zero",     64'(zero),     64'(e.zero));
        checkOutput("overflow", 64'(overflow), 64'(e.ovf));
        checkOutput("hi",       64'(hi),       64'(e.hi));
        checkOutput("lo",       64'(lo),       64'(e.lo));
        checkOutput("div_zero", 64'(div_zero), 64'(e.dz));
        checkOutput("latency",  64'(cycleCount - e.startCycle), 64'(e.latency));
        checkOutput("busy_len", 64'(busyCount), 64'(e.busyCycles));
      end
      busyCount = 0;
    end
  end

  // Issue one operation, scramble the inputs afterwards to show they are
  // not re-sampled, and wait (bounded) for the monitor to retire it.
  // intrudeAt > 0 pulses an ADD start that many cycles in, which must be
  // ignored while the operation is busy.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv, input int intrudeAt);
    exp_t e;
    int   waitCycles;
    @(negedge clk); #1;
    predict(op, av, bv, e);
    e.startCycle = cycleCount;
    expQ.push_back(e);
    start = 1'b1; a = av; b = bv; alu_control = op;
    @(negedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; alu_control = 4'($urandom);
    waitCycles = 1;
    while (expQ.size() != 0 && waitCycles < 200) begin
      @(negedge clk); #1;
      waitCycles++;
      if (intrudeAt != 0 && waitCycles == intrudeAt) begin
        start = 1'b1; alu_control = 4'b0010; a = $urandom; b = $urandom;
      end else start = 1'b0;
    end
    start = 1'b0;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done (op %0h)", waitCycles, op);
      expQ.delete();
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      resetModel();
      busyCount = 0;
    end
  endtask

  // Launch a MULT, poke an ADD start mid-flight, then reset before it can
  // finish: no done may appear and every output must be cleared.
  task automatic abortWithReset();
    @(negedge clk); #1;
    start = 1'b1; alu_control = 4'b1100; a = 32'hFFFF_FFFD; b = 32'd7;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (i == 10) begin start = 1'b1; alu_control = 4'b0010; a = 32'd1; b = 32'd2; end
      else start = 1'b0;
      if (i == 20) reset = 1'b1;
    end
    @(negedge clk); #1;
    start = 1'b0;
    checkOutput("abort_result",   64'(result),   64'd0);
    checkOutput("abort_zero",     64'(zero),     64'd0);
    checkOutput("abort_overflow", 64'(overflow), 64'd0);
    checkOutput("abort_hi",       64'(hi),       64'd0);
    checkOutput("abort_lo",       64'(lo),       64'd0);
    checkOutput("abort_busy",     64'(busy),     64'd0);
    checkOutput("abort_done",     64'(done),     64'd0);
    reset = 1'b0;
    resetModel();
    busyCount = 0;
  endtask

  // Watchdog so the run always ends even if the stimulus gets stuck.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, directed corner cases, busy/abort
  // scenarios, then randomized operations.
  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; alu_control = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_result",   64'(result),   64'd0);
    checkOutput("reset_zero",     64'(zero),     64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    checkOutput("reset_hi",       64'(hi),       64'd0);
    checkOutput("reset_lo",       64'(lo),       64'd0);
    checkOutput("reset_busy",     64'(busy),     64'd0);
    checkOutput("reset_done",     64'(done),     64'd0);
    checkOutput("reset_div_zero", 64'(div_zero), 64'd0);
    #1 reset = 1'b0;

    applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
    applyStimulus(4'b0110, 32'd5, 32'd5, 0);
    applyStimulus(4'b0110, 32'h8000_0000, 32'd1, 0);
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(4'b0101, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(4'b1010, 32'h8000_0000, 32'h0000_0024, 0);
    applyStimulus(4'b1000, 32'd1, 32'd31, 0);
    applyStimulus(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    applyStimulus(4'b0010, 32'h1234_5678, 32'h1111_1111, 0);
    applyStimulus(4'b1100, 32'hFFFF_FFFD, 32'd7, 0);
    applyStimulus(4'b1101, 32'hFFFF_FFFF, 32'd2, 0);
    applyStimulus(4'b1110, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(4'b1111, 32'd100, 32'd0, 0);
    applyStimulus(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(4'b1100, 32'hFFFF_FFF0, 32'h0000_1234, 10);
    abortWithReset();
    applyStimulus(4'b0010, 32'd3, 32'd4, 0);

    for (int n = 0; n < 60; n++) begin
      logic [3:0]  op;
      logic [31:0] ra;
      logic [31:0] rb;
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(0, 40));
        default: ;
      endcase
      applyStimulus(op, ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
